// File: rtl/a2pdp_pkg.sv
// Definitions shared between the RAM arbiter and the top-level bus decode.
package a2pdp_pkg;

    typedef enum logic [2:0] {
        ARB_INIT  = 3'd0,
        ARB_IDLE  = 3'd1,
        ARB_ISSUE = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_RESP  = 3'd4
    } arb_state_t;

    // Highest valid RAM word address; the top decode uses the same bound.
    localparam logic [21:0] HIMEM_ADDR = 22'o17757777;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the PSRAM controller command port between the DCJ11 bus and the DMA port.
// CPU has fixed priority; a starvation counter forces a DMA grant after STARVE_LIMIT CPU wins.
module ram_arbiter
    import a2pdp_pkg::*;
#(
    parameter logic [21:0] HIMEM        = HIMEM_ADDR,
    parameter int          STARVE_LIMIT = 4,
    parameter int          TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [21:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [15:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_byte,
    input  logic [21:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic [15:0] dma_rdata,

    output logic [21:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_read,
    output logic        ram_write,
    output logic        ram_byte,
    input  logic [15:0] ram_rdata,
    input  logic        ram_done,
    input  logic        ram_init,

    output logic        busy,
    output logic        owner
);

    localparam logic [7:0] STARVE_MAX  = 8'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

    arb_state_t  state_q, state_d;
    logic        owner_q, owner_d;
    logic [7:0]  starve_q, starve_d;
    logic [7:0]  wait_q, wait_d;
    logic [21:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic        dma_ack_q, dma_ack_d, dma_err_q, dma_err_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;

    logic        grant_dma;
    logic        sel_we, sel_byte;
    logic [21:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        rsp_fire, rsp_dma, rsp_err;
    logic [15:0] rsp_rdata;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        wait_d      = wait_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        byte_d      = byte_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        cpu_rdata_d = 16'h0000;
        dma_ack_d   = 1'b0;
        dma_err_d   = 1'b0;
        dma_rdata_d = 16'h0000;
        grant_dma   = dma_req && (!cpu_req || starve_q == STARVE_MAX);
        sel_we      = grant_dma ? dma_we    : cpu_we;
        sel_byte    = grant_dma ? dma_byte  : cpu_byte;
        sel_addr    = grant_dma ? dma_addr  : cpu_addr;
        sel_wdata   = grant_dma ? dma_wdata : cpu_wdata;
        rsp_fire    = 1'b0;
        rsp_dma     = owner_q;
        rsp_err     = 1'b0;
        rsp_rdata   = 16'h0000;

        case (state_q)
            ARB_INIT: begin
                if (ram_init) state_d = ARB_IDLE;
            end
            ARB_IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d = grant_dma ? REQ_DMA : REQ_CPU;
                    if (grant_dma || !dma_req)
                        starve_d = 8'd0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + 8'd1;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    byte_d  = sel_byte & sel_we;
                    if (sel_addr > HIMEM) begin
                        // Out-of-range access answers immediately without touching the RAM.
                        rsp_fire = 1'b1;
                        rsp_dma  = grant_dma;
                        rsp_err  = 1'b1;
                        state_d  = ARB_RESP;
                    end else begin
                        rd_d    = !sel_we;
                        wr_d    = sel_we;
                        state_d = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                wait_d  = 8'd0;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (ram_done) begin
                    rsp_fire  = 1'b1;
                    rsp_rdata = we_q ? 16'h0000 : ram_rdata;
                    state_d   = ARB_RESP;
                end else if (wait_q + 8'd1 == TIMEOUT_MAX) begin
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                    state_d  = ARB_RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_INIT;
        endcase

        if (rsp_fire) begin
            if (rsp_dma) begin
                dma_ack_d   = 1'b1;
                dma_err_d   = rsp_err;
                dma_rdata_d = rsp_rdata;
            end else begin
                cpu_ack_d   = 1'b1;
                cpu_err_d   = rsp_err;
                cpu_rdata_d = rsp_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_INIT;
            owner_q     <= 1'b0;
            starve_q    <= 8'd0;
            wait_q      <= 8'd0;
            addr_q      <= 22'd0;
            wdata_q     <= 16'h0000;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            cpu_rdata_q <= 16'h0000;
            dma_ack_q   <= 1'b0;
            dma_err_q   <= 1'b0;
            dma_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            wait_q      <= wait_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_ack_q   <= dma_ack_d;
            dma_err_q   <= dma_err_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_err   = dma_err_q;
    assign dma_rdata = dma_rdata_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_read  = rd_q;
    assign ram_write = wr_q;
    assign ram_byte  = byte_q;
    assign owner     = owner_q;
    // Calibration wait is not an access, so busy stays low in INIT as it does out of reset.
    assign busy      = (state_q != ARB_IDLE) && (state_q != ARB_INIT);

endmodule
